// File: rtl/sprite_pixel_selector_pkg.sv
// sprite_pixel_selector_pkg: register field positions, FSM states and colour defaults shared by the selector
package sprite_pixel_selector_pkg;
  localparam int X_MSB = 28;
  localparam int X_LSB = 19;
  localparam int Y_MSB = 18;
  localparam int Y_LSB = 9;
  localparam int ID_MSB = 8;
  localparam int ID_LSB = 0;
  localparam logic [8:0] TRANSP_DEF = 9'h1FF;
  localparam logic [8:0] BG_COLOR_DEF = 9'h000;
  typedef enum logic [2:0] {IDLE, SEARCH, FETCH, WAIT, DONE} state_t;
endpackage

// File: rtl/sprite_pixel_selector_if.sv
// sprite_pixel_selector_if: request, register-read, memory-read and result signals of the selector
// master: the selector (drives reg_idx, mem_rd, mem_addr, out_color, out_valid, busy)
// slave: its environment (drives start, hits, check, reg_data, mem_data)
interface sprite_pixel_selector_if #(parameter int ADDR_W = 15);
  logic start;
  logic [31:0] hits;
  logic [19:0] check;
  logic [4:0] reg_idx;
  logic [31:0] reg_data;
  logic mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [8:0] mem_data;
  logic [8:0] out_color;
  logic out_valid;
  logic busy;
  modport master(input start, hits, check, reg_data, mem_data,
                 output reg_idx, mem_rd, mem_addr, out_color, out_valid, busy);
  modport slave(output start, hits, check, reg_data, mem_data,
                input reg_idx, mem_rd, mem_addr, out_color, out_valid, busy);
endinterface

// File: rtl/sprite_pixel_selector_pri_enc31.sv
// pri_enc31: lowest-set-bit encoder; vec in, idx = lowest set bit, any = vec nonzero
module pri_enc31 (
  input  logic [30:0] vec,
  output logic [4:0]  idx,
  output logic        any
);
  always_comb begin
    idx = '0;
    for (int i = 30; i >= 0; i--) if (vec[i]) idx = 5'(i);
  end
  assign any = |vec;
endmodule

// File: rtl/sprite_pixel_selector.sv
// sprite_pixel_selector: walks hit sprites lowest index first and returns the first opaque pixel or BG_COLOR
// clk, reset (async, active-low); bus.master carries start/hits/check in, register and memory reads, out_color/out_valid/busy out
module sprite_pixel_selector
  import sprite_pixel_selector_pkg::*;
#(
  parameter int ADDR_W = 15,
  parameter int SPR_LINE = 20,
  parameter logic [8:0] TRANSP = TRANSP_DEF,
  parameter logic [8:0] BG_COLOR = BG_COLOR_DEF
) (
  input logic clk,
  input logic reset,
  sprite_pixel_selector_if.master bus
);
  state_t state, next;
  logic [30:0] pend;
  logic [19:0] pos;
  logic [4:0] k;
  logic any;
  logic [9:0] dx, dy;
  logic [31:0] addr;
  pri_enc31 u_pe (.vec(pend), .idx(k), .any(any));
  // 10-bit wrapping differences: upstream guarantees the pixel lies inside the sprite
  assign dx = pos[19:10] - bus.reg_data[X_MSB:X_LSB];
  assign dy = pos[9:0] - bus.reg_data[Y_MSB:Y_LSB];
  assign addr = 32'(bus.reg_data[ID_MSB:ID_LSB]) * 32'(SPR_LINE * SPR_LINE)
              + 32'(dy) * 32'(SPR_LINE) + 32'(dx);
  assign bus.mem_rd = state == FETCH;
  assign bus.mem_addr = bus.mem_rd ? addr[ADDR_W-1:0] : '0;
  assign bus.out_valid = state == DONE;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    next = bus.start ? SEARCH : IDLE;
      SEARCH:  next = any ? FETCH : DONE;
      FETCH:   next = WAIT;
      WAIT:    next = bus.mem_data == TRANSP ? SEARCH : DONE;
      default: next = IDLE;
    endcase
  end
  // reg_idx doubles as the latched candidate index k while FETCH/WAIT run
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pend <= '0;
      pos <= '0;
      bus.reg_idx <= '0;
      bus.out_color <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        pend <= bus.hits[30:0];
        pos <= bus.check;
      end
      if (state == SEARCH && any) bus.reg_idx <= k;
      if (state == SEARCH && !any) bus.out_color <= BG_COLOR;
      if (state == WAIT && bus.mem_data == TRANSP) pend[bus.reg_idx] <= 1'b0;
      if (state == WAIT && bus.mem_data != TRANSP) bus.out_color <= bus.mem_data;
    end
endmodule

// File: doc/sprite_pixel_selector.md
SPRITE_PIXEL_SELECTOR -- requirements
Module: sprite_pixel_selector

Interface
REQ-001 Parameter ADDR_W, 15: sprite memory address width.
REQ-002 Parameter SPR_LINE, 20: sprite width and height in pixels; the sprite size is SPR_LINE*SPR_LINE.
REQ-003 Parameter TRANSP, 9'h1FF: 9-bit RGB333 code treated as transparent.
REQ-004 Parameter BG_COLOR, 9'h000: colour output when no opaque sprite pixel is found.
REQ-005 Port clk, input, 1: clock.
REQ-006 Port reset, input, 1: reset, asynchronous, active-low.
REQ-007 Port start, input, 1: pulse; the hit vector and pixel coordinate are valid in this cycle.
REQ-008 Port hits, input, 32: per-sprite hit vector from the comparator stage; bit i is register i+1; bit 31 is ignored.
REQ-009 Port check, input, 20: current pixel coordinate; x is check[19:10], y is check[9:0].
REQ-010 Port reg_idx, output, 5: index (0..30) of the sprite register to read.
REQ-011 Port reg_data, input, 32: combinational read data of register reg_idx+1; x is [28:19], y is [18:9], sprite id is [8:0].
REQ-012 Port mem_rd, output, 1: sprite memory read strobe.
REQ-013 Port mem_addr, output, ADDR_W: sprite memory address.
REQ-014 Port mem_data, input, 9: RGB333 pixel, valid exactly one cycle after mem_rd.
REQ-015 Port out_color, output, 9: selected pixel colour.
REQ-016 Port out_valid, output, 1: one-cycle pulse qualifying out_color.
REQ-017 Port busy, output, 1: high in every state except IDLE.

Function
REQ-018 The FSM SHALL use the states IDLE, SEARCH, FETCH, WAIT and DONE.
REQ-019 IDLE with start=1: latch hits[30:0] into the pending mask and latch check, then go to SEARCH; start is ignored in all other states.
REQ-020 SEARCH: if the pending mask is zero, load out_color=BG_COLOR and go to DONE; otherwise latch the lowest set index k and go to FETCH. Lowest index has highest priority.
REQ-021 FETCH: drive reg_idx=k and mem_rd=1, with mem_addr = id*SPR_LINE*SPR_LINE + (py-y)*SPR_LINE + (px-x), truncated mod 2^ADDR_W; go to WAIT.
REQ-022 The dx and dy subtractions SHALL be 10-bit unsigned; no range check is made (upstream guarantees a hit).
REQ-023 WAIT: if mem_data==TRANSP, clear bit k in the pending mask and go to SEARCH; otherwise load out_color=mem_data and go to DONE.
REQ-024 DONE: assert out_valid=1 for exactly one cycle and return to IDLE.
REQ-025 mem_rd SHALL be high only in FETCH; reg_idx SHALL hold its last value outside FETCH.
REQ-026 Latency from start (cycle 0): no hits gives out_valid in cycle 2; first candidate opaque gives cycle 4; each transparent candidate adds 3 cycles.
REQ-027 Worst case (31 transparent hits) SHALL produce out_valid=1 with BG_COLOR in cycle 95.
REQ-028 out_color SHALL hold its value until the next DONE.

Reset
REQ-029 reset=0 SHALL immediately force IDLE, pending mask 0, reg_idx 0, mem_rd 0, mem_addr 0, out_color 0, out_valid 0 and busy 0, including mid-search.
REQ-030 After reset is released, the first start SHALL be processed normally; a mem_data response left over from an aborted read SHALL be ignored.

Structure
REQ-031 A shared package SHALL hold the register field positions (X_MSB/LSB 28/19, Y 18/9, ID 8/0), the state enum, and the TRANSP and BG_COLOR defaults.
REQ-032 The lowest-set-bit search SHALL be a combinational sub-module pri_enc31 (31-bit input, 5-bit index, 1-bit any).

Verification
REQ-033 hits=0, start pulse -> out_valid in cycle 2, out_color=BG_COLOR, mem_rd never asserted.
REQ-034 hits=32'h0000_0004; register 3 has x=100, y=50, id=2; check x=105, y=57 -> reg_idx=2, mem_addr=800+140+5=945; mem_data=9'h0A5 -> out_color=9'h0A5 in cycle 4.
REQ-035 hits=32'h0000_0011, bit 0 pixel=TRANSP, bit 4 pixel=9'h038 -> two reads (reg_idx 0, then 4), out_color=9'h038 in cycle 7.
REQ-036 hits=32'hFFFF_FFFF, all pixels TRANSP -> 31 reads, none for bit 31, out_color=BG_COLOR in cycle 95.
REQ-037 start re-pulsed while busy -> ignored, single out_valid; reset=0 asserted in WAIT -> all outputs 0 at once, next start completes correctly.
